// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : router_fifo
//  Purpose  : Per-destination output FIFO of the 1x3 router. Stores
//             {hdr_flag, byte} words and tracks the bytes remaining in the
//             packet currently being drained on the read side.
//  Revision : 1.0  initial release
// ============================================================================
module router_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              soft_reset,
   input  logic              write_enb,
   input  logic              read_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              pkt_busy
);

   localparam int CNT_W = 7;

   // Storage: MSB of each word is the header marker captured from lfd_state.
   logic [DATA_W:0]   mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [CNT_W-1:0]  pkt_cnt;

   logic              clear;
   logic              wr_do;
   logic              rd_do;
   logic [DATA_W:0]   rd_word;
   logic [CNT_W-1:0]  pkt_cnt_nxt;

   // Flags come straight from the pointers; the extra wrap bit separates full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

   // Both operations are qualified by flags sampled before the edge, so a
   // read on full frees a slot too late for a same-cycle write, and a write
   // on empty is not yet visible to a same-cycle read.
   assign clear   = !resetn || soft_reset;
   assign wr_do   = write_enb && !full;
   assign rd_do   = read_enb && !empty;
   assign rd_word = mem[rd_ptr[ADDR_W-1:0]];
   assign pkt_busy = (pkt_cnt != '0);

   // Next packet count for a successful read: header reloads (length + parity),
   // other bytes count down, stray bytes leave the count at zero.
   always_comb begin
      pkt_cnt_nxt = pkt_cnt;
      if (rd_word[DATA_W]) begin
         pkt_cnt_nxt = {1'b0, rd_word[7:2]} + 7'd1;
      end else if (pkt_cnt != '0) begin
         pkt_cnt_nxt = pkt_cnt - 7'd1;
      end
   end

   // Memory write port; writes in a flush or reset cycle are discarded.
   always_ff @(posedge clock) begin
      if (wr_do && !clear) begin
         mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
      end
   end

   // Pointers, read data register and packet counter.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (soft_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         if (wr_do) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_do) begin
            rd_ptr     <= rd_ptr + 1'b1;
            data_out   <= rd_word[DATA_W-1:0];
            data_valid <= 1'b1;
            pkt_cnt    <= pkt_cnt_nxt;
         end else begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_fifo
//  Purpose  : Directed self-checking bench for router_fifo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_router_fifo;

   logic       clock;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic       full;
   logic       empty;
   logic [7:0] data_out;
   logic       data_valid;
   logic       pkt_busy;

   int checks = 0;
   int errors = 0;

   router_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .full       (full),
      .empty      (empty),
      .data_out   (data_out),
      .data_valid (data_valid),
      .pkt_busy   (pkt_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d, input logic hdr);
      write_enb = 1'b1; lfd_state = hdr; data_in = d;
      tick();
      write_enb = 1'b0; lfd_state = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] exp);
      read_enb = 1'b1;
      tick();
      read_enb = 1'b0;
      chk({tag, "_data"}, 32'(data_out), 32'(exp));
      chk({tag, "_valid"}, 32'(data_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
      lfd_state = 1'b0; data_in = 8'h00;
      #2;

      // 1: reset holds everything clear, writes during reset are not stored
      write_enb = 1'b1; data_in = 8'h77;
      tick(); tick();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_busy", 32'(pkt_busy), 32'd0);
      write_enb = 1'b0; resetn = 1'b1;
      tick();
      chk("rst_nothing_stored", 32'(empty), 32'd1);

      // 2: packet pass-through, header 0x0D -> len 3 -> count 4
      wr(8'h0D, 1'b1); wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0); wr(8'h1F, 1'b0);
      chk("pkt_not_empty", 32'(empty), 32'd0);
      rd("pkt_hdr", 8'h0D);
      chk("pkt_busy_hdr", 32'(pkt_busy), 32'd1);
      chk("pkt_cnt_hdr", 32'(dut.pkt_cnt), 32'd4);
      rd("pkt_b1", 8'h11);
      chk("pkt_cnt_b1", 32'(dut.pkt_cnt), 32'd3);
      rd("pkt_b2", 8'h22);
      rd("pkt_b3", 8'h33);
      chk("pkt_busy_b3", 32'(pkt_busy), 32'd1);
      rd("pkt_par", 8'h1F);
      chk("pkt_busy_end", 32'(pkt_busy), 32'd0);
      tick();
      chk("pkt_valid_drop", 32'(data_valid), 32'd0);
      chk("pkt_dout_hold", 32'(data_out), 32'h1F);
      chk("pkt_empty", 32'(empty), 32'd1);

      // 3: full boundary, 17th write dropped
      for (int i = 0; i < 16; i++) begin
         chk("fill_not_full", 32'(full), 32'd0);
         wr(8'(8'h40 + i), 1'b0);
      end
      chk("fill_full", 32'(full), 32'd1);
      wr(8'hAA, 1'b0);
      chk("fill_full_after_drop", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         rd("fill_rd", 8'(8'h40 + i));
      end
      chk("fill_cnt_stray", 32'(dut.pkt_cnt), 32'd0);
      chk("fill_empty", 32'(empty), 32'd1);

      // 4: simultaneous read/write while full
      for (int i = 0; i < 16; i++) wr(8'(8'h60 + i), 1'b0);
      chk("rw_full_pre", 32'(full), 32'd1);
      read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hBB;
      tick();
      read_enb = 1'b0; write_enb = 1'b0;
      chk("rw_full_data", 32'(data_out), 32'h60);
      chk("rw_full_valid", 32'(data_valid), 32'd1);
      chk("rw_full_flag", 32'(full), 32'd0);
      for (int i = 1; i < 16; i++) begin
         rd("rw_full_rd", 8'(8'h60 + i));
      end
      chk("rw_full_occ15", 32'(empty), 32'd1);

      // 5: simultaneous read/write while empty
      read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h5C;
      tick();
      read_enb = 1'b0; write_enb = 1'b0;
      chk("rw_empty_valid", 32'(data_valid), 32'd0);
      chk("rw_empty_flag", 32'(empty), 32'd0);
      rd("rw_empty_rd", 8'h5C);
      chk("rw_empty_after", 32'(empty), 32'd1);

      // 6: soft reset mid-packet, then a packet across the address wrap
      wr(8'h0D, 1'b1); wr(8'hA1, 1'b0); wr(8'hA2, 1'b0); wr(8'hA3, 1'b0); wr(8'h5E, 1'b0);
      rd("sr_hdr", 8'h0D);
      rd("sr_b1", 8'hA1);
      rd("sr_b2", 8'hA2);
      chk("sr_cnt_pre", 32'(dut.pkt_cnt), 32'd2);
      soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'hEE;
      tick();
      soft_reset = 1'b0; write_enb = 1'b0;
      chk("sr_empty", 32'(empty), 32'd1);
      chk("sr_busy", 32'(pkt_busy), 32'd0);
      chk("sr_dout", 32'(data_out), 32'd0);
      chk("sr_valid", 32'(data_valid), 32'd0);
      for (int i = 0; i < 14; i++) wr(8'(8'h80 + i), 1'b0);
      for (int i = 0; i < 14; i++) rd("sr_filler", 8'(8'h80 + i));
      wr(8'h09, 1'b1); wr(8'hC1, 1'b0); wr(8'hC2, 1'b0); wr(8'hCA, 1'b0);
      rd("wrap_hdr", 8'h09);
      chk("wrap_cnt", 32'(dut.pkt_cnt), 32'd3);
      rd("wrap_b1", 8'hC1);
      rd("wrap_b2", 8'hC2);
      chk("wrap_busy_mid", 32'(pkt_busy), 32'd1);
      rd("wrap_par", 8'hCA);
      chk("wrap_busy_end", 32'(pkt_busy), 32'd0);
      chk("wrap_empty", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
